vend_dispense_ctrl: RTL and testbench

Dispense sequencer behind the vending_machine core. Takes a completed-sale request (product code and change count), checks per-product stock, and drives the selected motor for a fixed time. It then pulses the coin ejector once per change unit and returns a one-cycle acknowledge. It owns the stock counters and a restock load port.

---
 rtl/vend_dispense_ctrl.sv | 162 ++++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: checks stock for a completed sale, runs the product motor,
// pulses the coin ejector once per change unit, and owns the per-product stock counters.
module vend_dispense_ctrl #(
    parameter int MOTOR_CYCLES = 4,
    parameter int COIN_ON      = 2,
    parameter int COIN_OFF     = 2,
    parameter int STOCK_W      = 4,
    parameter int INIT_STOCK   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [1:0]         req_product,
    input  logic [2:0]         req_change,
    output logic               busy,
    output logic [3:0]         motor,
    output logic               coin_eject,
    output logic               ack,
    output logic               sold_out,
    input  logic               stock_load,
    input  logic [1:0]         load_product,
    input  logic [STOCK_W-1:0] load_count,
    output logic [3:0]         stock_empty
);

    typedef enum logic [2:0] {IDLE, MOTOR, COIN_H, COIN_L, DONE} state_t;

    localparam logic [15:0] MOTOR_LAST = 16'(MOTOR_CYCLES - 1);
    localparam logic [15:0] ON_LAST    = 16'(COIN_ON - 1);
    localparam logic [15:0] OFF_LAST   = 16'(COIN_OFF - 1);

    state_t             state_reg;
    logic [15:0]        cnt_reg;
    logic [1:0]         prod_reg;
    logic [2:0]         coins_reg;
    logic               sold_reg;
    logic               busy_reg;
    logic [3:0]         motor_reg;
    logic               coin_reg;
    logic               ack_reg;
    logic               sold_out_reg;
    logic [4*STOCK_W-1:0] stock_vec;
    logic [STOCK_W-1:0] req_stock;
    logic               dec_en;

    assign req_stock = stock_vec[req_product*STOCK_W +: STOCK_W];
    assign dec_en    = (state_reg == MOTOR) && (cnt_reg == 16'd0);

    // Load beats a same-edge decrement; decrement is guarded so it can never wrap.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_stock
            logic [STOCK_W-1:0] stock_reg;
            always_ff @(posedge clk) begin
                if (rst)
                    stock_reg <= STOCK_W'(INIT_STOCK);
                else if (stock_load && load_product == 2'(gi))
                    stock_reg <= load_count;
                else if (dec_en && prod_reg == 2'(gi) && stock_reg != '0)
                    stock_reg <= stock_reg - STOCK_W'(1);
            end
            assign stock_vec[gi*STOCK_W +: STOCK_W] = stock_reg;
            assign stock_empty[gi] = (stock_reg == '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            prod_reg     <= '0;
            coins_reg    <= '0;
            sold_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            motor_reg    <= '0;
            coin_reg     <= 1'b0;
            ack_reg      <= 1'b0;
            sold_out_reg <= 1'b0;
        end else begin
            ack_reg      <= 1'b0;
            sold_out_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        prod_reg  <= req_product;
                        coins_reg <= req_change;
                        busy_reg  <= 1'b1;
                        if (req_stock != '0) begin
                            state_reg <= MOTOR;
                            motor_reg <= 4'b0001 << req_product;
                            cnt_reg   <= MOTOR_LAST;
                            sold_reg  <= 1'b0;
                        end else begin
                            sold_reg <= 1'b1;
                            if (req_change != 3'd0) begin
                                state_reg <= COIN_H;
                                coin_reg  <= 1'b1;
                                cnt_reg   <= ON_LAST;
                            end else begin
                                state_reg    <= DONE;
                                ack_reg      <= 1'b1;
                                sold_out_reg <= 1'b1;
                            end
                        end
                    end
                end
                MOTOR: begin
                    if (cnt_reg == 16'd0) begin
                        motor_reg <= '0;
                        if (coins_reg != 3'd0) begin
                            state_reg <= COIN_H;
                            coin_reg  <= 1'b1;
                            cnt_reg   <= ON_LAST;
                        end else begin
                            state_reg    <= DONE;
                            ack_reg      <= 1'b1;
                            sold_out_reg <= sold_reg;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 16'd1;
                    end
                end
                COIN_H: begin
                    if (cnt_reg == 16'd0) begin
                        state_reg <= COIN_L;
                        coin_reg  <= 1'b0;
                        coins_reg <= coins_reg - 3'd1;
                        cnt_reg   <= OFF_LAST;
                    end else begin
                        cnt_reg <= cnt_reg - 16'd1;
                    end
                end
                COIN_L: begin
                    if (cnt_reg == 16'd0) begin
                        if (coins_reg != 3'd0) begin
                            state_reg <= COIN_H;
                            coin_reg  <= 1'b1;
                            cnt_reg   <= ON_LAST;
                        end else begin
                            state_reg    <= DONE;
                            ack_reg      <= 1'b1;
                            sold_out_reg <= sold_reg;
                        end
                    end else begin
                        cnt_reg <= cnt_reg - 16'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy       = busy_reg;
    assign motor      = motor_reg;
    assign coin_eject = coin_reg;
    assign ack        = ack_reg;
    assign sold_out   = sold_out_reg;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: a vector table of sale requests with
// hand-computed per-cycle masks, plus sequences for load races, held req and reset.
module tb_vend_dispense_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req_a, req_b, busy_a, busy_b, coin_a, coin_b, ack_a, ack_b, so_a, so_b;
    logic [1:0] prod_a, prod_b, lprod_a, lprod_b;
    logic [2:0] chg_a, chg_b;
    logic [3:0] motor_a, motor_b, empty_a, empty_b, lcnt_a, lcnt_b;
    logic       load_a, load_b;

    vend_dispense_ctrl dut_a (
        .clk(clk), .rst(rst), .req(req_a), .req_product(prod_a), .req_change(chg_a),
        .busy(busy_a), .motor(motor_a), .coin_eject(coin_a), .ack(ack_a), .sold_out(so_a),
        .stock_load(load_a), .load_product(lprod_a), .load_count(lcnt_a), .stock_empty(empty_a)
    );

    vend_dispense_ctrl #(.MOTOR_CYCLES(1), .COIN_ON(1), .COIN_OFF(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .req_product(prod_b), .req_change(chg_b),
        .busy(busy_b), .motor(motor_b), .coin_eject(coin_b), .ack(ack_b), .sold_out(so_b),
        .stock_load(load_b), .load_product(lprod_b), .load_count(lcnt_b), .stock_empty(empty_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  p;
        logic [2:0]  n;
        logic [31:0] motor_mask;
        logic [3:0]  motor_val;
        logic [31:0] coin_mask;
        int          ack_cyc;
        logic        sold;
        logic [3:0]  empty;
    } vec_t;

    vec_t tbl[9];

    // Issue one request and record per-cycle behaviour (bit k = cycle k after E0).
    task automatic run_req(input bit sel, input logic [1:0] p, input logic [2:0] n,
                           output logic [31:0] mm, output logic [3:0] mv,
                           output logic [31:0] cm, output int ack_cyc,
                           output logic sold, output logic excl);
        logic [3:0] m;
        logic       c, a, s;
        mm = '0; mv = '0; cm = '0; ack_cyc = -1; sold = 1'b0; excl = 1'b1;
        if (sel) begin req_b = 1'b1; prod_b = p; chg_b = n; end
        else     begin req_a = 1'b1; prod_a = p; chg_a = n; end
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0;
        for (int k = 1; k < 32; k++) begin
            m = sel ? motor_b : motor_a;
            c = sel ? coin_b : coin_a;
            a = sel ? ack_b : ack_a;
            s = sel ? so_b : so_a;
            if (m != 4'd0) begin mm[k] = 1'b1; mv = mv | m; end
            if (c) cm[k] = 1'b1;
            if ((m != 4'd0 && c) || $countones(m) > 1) excl = 1'b0;
            if (a) begin ack_cyc = k; sold = s; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] mm, cm, ackm, busylow;
        logic [3:0]  mv;
        int          ac;
        logic        sd, ex, ack_seen;

        rst = 1'b1;
        req_a = 0; prod_a = 0; chg_a = 0; load_a = 0; lprod_a = 0; lcnt_a = 0;
        req_b = 0; prod_b = 0; chg_b = 0; load_b = 0; lprod_b = 0; lcnt_b = 0;

        tbl[0] = '{2'd2, 3'd3, 32'h1E, 4'b0100, 32'h6660, 17, 1'b0, 4'b0000};
        for (int i = 1; i <= 5; i++)
            tbl[i] = '{2'd1, 3'd0, 32'h1E, 4'b0010, 32'h0, 5, 1'b0,
                       (i == 5) ? 4'b0010 : 4'b0000};
        tbl[6] = '{2'd1, 3'd2, 32'h0,  4'b0000, 32'h66,  9,  1'b1, 4'b0010};
        tbl[7] = '{2'd3, 3'd1, 32'h1E, 4'b1000, 32'h60,  9,  1'b0, 4'b0010};
        tbl[8] = '{2'd0, 3'd2, 32'h1E, 4'b0001, 32'h660, 13, 1'b0, 4'b0010};

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset outputs", {27'd0, busy_a, motor_a, coin_a, ack_a, so_a}, 32'd0);
        check("reset empty", {28'd0, empty_a}, 32'd0);
        check("reset stock", {16'd0, dut_a.stock_vec}, 32'h5555);

        for (int i = 0; i < 9; i++) begin
            run_req(1'b0, tbl[i].p, tbl[i].n, mm, mv, cm, ac, sd, ex);
            check($sformatf("v%0d motor_mask", i), mm, tbl[i].motor_mask);
            check($sformatf("v%0d motor_val", i), {28'd0, mv}, {28'd0, tbl[i].motor_val});
            check($sformatf("v%0d coin_mask", i), cm, tbl[i].coin_mask);
            check($sformatf("v%0d ack_cycle", i), 32'(ac), 32'(tbl[i].ack_cyc));
            check($sformatf("v%0d sold_out", i), {31'd0, sd}, {31'd0, tbl[i].sold});
            check($sformatf("v%0d exclusive", i), {31'd0, ex}, 32'd1);
            check($sformatf("v%0d empty", i), {28'd0, empty_a}, {28'd0, tbl[i].empty});
        end
        check("table stock", {16'd0, dut_a.stock_vec}, 32'h4404);

        // Restock p1 to 3, then load 0 on the very edge that ends MOTOR.
        load_a = 1'b1; lprod_a = 2'd1; lcnt_a = 4'd3;
        @(posedge clk); #1 load_a = 1'b0;
        check("restock empty", {28'd0, empty_a}, 32'd0);
        req_a = 1'b1; prod_a = 2'd1; chg_a = 3'd0;
        @(posedge clk); #1 req_a = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        load_a = 1'b1; lprod_a = 2'd1; lcnt_a = 4'd0;
        @(posedge clk); #1 load_a = 1'b0;
        check("loadwin ack", {31'd0, ack_a}, 32'd1);
        check("loadwin motor", {28'd0, motor_a}, 32'd0);
        @(posedge clk); #1;
        check("loadwin empty", {28'd0, empty_a}, 32'h2);
        check("loadwin stock1", {28'd0, dut_a.stock_vec[7:4]}, 32'd0);

        // Same-edge load and request: the request sees the old (zero) stock.
        load_a = 1'b1; lprod_a = 2'd0; lcnt_a = 4'd0;
        @(posedge clk); #1;
        lcnt_a = 4'd5; req_a = 1'b1; prod_a = 2'd0; chg_a = 3'd0;
        @(posedge clk); #1 load_a = 1'b0; req_a = 1'b0;
        check("oldstock ack", {31'd0, ack_a}, 32'd1);
        check("oldstock sold_out", {31'd0, so_a}, 32'd1);
        check("oldstock motor", {28'd0, motor_a}, 32'd0);
        @(posedge clk); #1;
        check("oldstock empty", {28'd0, empty_a}, 32'h2);

        // req held high: second capture only on the edge after the DONE cycle's follower.
        mm = '0; ackm = '0; busylow = '0;
        req_a = 1'b1; prod_a = 2'd3; chg_a = 3'd1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 20) req_a = 1'b0;
            if (motor_a != 4'd0) mm[k] = 1'b1;
            if (ack_a) ackm[k] = 1'b1;
            if (!busy_a) busylow[k] = 1'b1;
        end
        check("held motor_mask", mm, 32'h781E);
        check("held ack_mask", ackm, 32'h80200);
        check("held busy_low", busylow, 32'h100400);
        @(posedge clk); #1;
        check("held no third", {31'd0, busy_a}, 32'd0);

        // Reset during cycle 3 of MOTOR.
        req_a = 1'b1; prod_a = 2'd0; chg_a = 3'd0;
        @(posedge clk); #1 req_a = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("rst motor", {28'd0, motor_a}, 32'd0);
        check("rst busy", {31'd0, busy_a}, 32'd0);
        ack_seen = 1'b0;
        repeat (8) begin
            if (ack_a) ack_seen = 1'b1;
            @(posedge clk); #1;
        end
        check("rst no ack", {31'd0, ack_seen}, 32'd0);
        check("rst stock", {16'd0, dut_a.stock_vec}, 32'h5555);

        // Fast parameter set: 7 coins on even cycles 2..14, ack at 16.
        run_req(1'b1, 2'd0, 3'd7, mm, mv, cm, ac, sd, ex);
        check("fast motor_mask", mm, 32'h2);
        check("fast motor_val", {28'd0, mv}, 32'h1);
        check("fast coin_mask", cm, 32'h5554);
        check("fast ack_cycle", 32'(ac), 32'd16);
        check("fast sold_out", {31'd0, sd}, 32'd0);
        check("fast exclusive", {31'd0, ex}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
